// File: rtl/conv_output_frame_collector.sv
// conv_output_frame_collector
//
// Gathers the raster-ordered stream of per-window results coming out of the
// 3x3 convolution stage into an on-chip frame buffer. Once the whole output
// map is in memory it is replayed to the next layer over valid/ready, tagged
// with its output-map row/column and a last flag.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start             : frame start pulse, only honoured while idle
//   img_width/height  : input image size W/H, sampled with start
//   padding_mode      : 00 none, 01 zero, 10 edge, 11 same as 01
//   valid_in, data_in : result stream from the compute stage (no backpressure)
//   out_valid/ready   : replay handshake
//   out_data          : replayed result
//   out_row, out_col  : output-map coordinates of out_data
//   out_last          : marks the final result of the frame
//   frame_done        : one-cycle pulse after the final handshake
//   busy              : collector is not idle
//   err               : sticky error, cleared by reset or an accepted start
module conv_output_frame_collector #(
  parameter int DATA_W   = 8,
  parameter int MAX_SIZE = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               img_width,
  input  logic [7:0]               img_height,
  input  logic [1:0]               padding_mode,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [7:0]               out_row,
  output logic [7:0]               out_col,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     err
);

  localparam int          ADDR_W       = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam logic [15:0] MAX_EXPECTED = 16'(MAX_SIZE);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] mem [MAX_SIZE];

  logic [7:0]  out_w_q;
  logic [15:0] expected_q;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;

  logic        no_pad;
  logic [7:0]  calc_w;
  logic [7:0]  calc_h;
  logic [15:0] calc_expected;
  logic [15:0] last_idx;
  logic [15:0] rd_next;
  logic        cfg_bad;
  logic        accept_start;
  logic        write_en;
  logic        last_write;
  logic        handshake;
  logic        last_read;
  logic        first_fetch;

  // Frame geometry derived straight from the configuration inputs, so that it
  // can be validated in the same cycle start is seen.
  always_comb begin
    no_pad        = (padding_mode == 2'b00);
    calc_w        = no_pad ? (img_width  - 8'd2) : img_width;
    calc_h        = no_pad ? (img_height - 8'd2) : img_height;
    calc_expected = {8'd0, calc_w} * {8'd0, calc_h};
    cfg_bad       = (no_pad && ((img_width < 8'd3) || (img_height < 8'd3))) ||
                    (calc_expected == 16'd0) || (calc_expected > MAX_EXPECTED);
    accept_start  = (state == IDLE) && start && !cfg_bad;
    last_idx      = expected_q - 16'd1;
    write_en      = (state == COLLECT) && valid_in;
    last_write    = write_en && (wr_cnt == last_idx);
    handshake     = (state == DRAIN) && out_valid && out_ready;
    last_read     = handshake && (rd_cnt == last_idx);
    // The first DRAIN cycle has nothing presented yet; it prefetches mem[0].
    first_fetch   = (state == DRAIN) && !out_valid;
    rd_next       = rd_cnt + 16'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_start) state_next = COLLECT;
      COLLECT: if (last_write)   state_next = DRAIN;
      DRAIN:   if (last_read)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Frame buffer; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_cnt[ADDR_W-1:0]] <= data_in;
    end
  end

  // Counters, error flag and the registered replay outputs. The output
  // registers only move on a handshake (or the initial prefetch), which keeps
  // them stable during backpressure. On a handshake the next word is read
  // directly so the stream runs without bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_w_q    <= '0;
      expected_q <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= last_read;

      // A start and a stray valid_in together: the start decides the flag,
      // but the dropped result still has to be reported.
      if ((state == IDLE) && start) begin
        err <= cfg_bad | valid_in;
      end else if (valid_in && (state != COLLECT)) begin
        err <= 1'b1;
      end

      if (accept_start) begin
        out_w_q    <= calc_w;
        expected_q <= calc_expected;
        wr_cnt     <= '0;
      end

      if (write_en) begin
        wr_cnt <= wr_cnt + 16'd1;
      end

      if (last_write) begin
        rd_cnt <= '0;
      end

      if (first_fetch) begin
        out_valid <= 1'b1;
        out_data  <= mem[{ADDR_W{1'b0}}];
        out_row   <= '0;
        out_col   <= '0;
        out_last  <= (expected_q == 16'd1);
        rd_cnt    <= '0;
      end else if (handshake) begin
        if (last_read) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          rd_cnt   <= rd_next;
          out_data <= mem[rd_next[ADDR_W-1:0]];
          out_last <= (rd_next == last_idx);
          if (out_col == (out_w_q - 8'd1)) begin
            out_col <= '0;
            out_row <= out_row + 8'd1;
          end else begin
            out_col <= out_col + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_output_frame_collector.sv
// tb_conv_output_frame_collector
//
// Directed bench for conv_output_frame_collector. A frame-level model
// (list of received results turned into (value,row,col,last) tuples by plain
// division/modulo) is compared against the replay outputs on every cycle,
// together with busy, err and frame_done. Literal expectations in the
// directed scenarios pin the model itself.
module tb_conv_output_frame_collector;

  localparam int DATA_W   = 8;
  localparam int MAX_SIZE = 256;

  logic                     clk          = 1'b0;
  logic                     rst_n        = 1'b0;
  logic                     start        = 1'b0;
  logic [7:0]               img_width    = '0;
  logic [7:0]               img_height   = '0;
  logic [1:0]               padding_mode = '0;
  logic                     valid_in     = 1'b0;
  logic signed [DATA_W-1:0] data_in      = '0;
  logic                     out_ready    = 1'b1;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic [7:0]               out_row;
  logic [7:0]               out_col;
  logic                     out_last;
  logic                     frame_done;
  logic                     busy;
  logic                     err;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int data;
    int row;
    int col;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   recv_q[$];
  int   m_phase    = 0;
  int   m_expected = 0;
  int   m_out_w    = 0;
  bit   m_err      = 1'b0;
  bit   m_done     = 1'b0;

  int last_data = 0;
  int last_row  = -1;
  int last_col  = -1;

  int vals2[6] = '{10, -20, 30, -40, 50, -60};

  conv_output_frame_collector #(
    .DATA_W   (DATA_W),
    .MAX_SIZE (MAX_SIZE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .img_width    (img_width),
    .img_height   (img_height),
    .padding_mode (padding_mode),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_last     (out_last),
    .frame_done   (frame_done),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; they are sampled by the next rising edge.
  task automatic applyStimulus(input bit st, input int w, input int h, input int mode,
                               input bit vld, input int dat);
    start        = st;
    img_width    = 8'(w);
    img_height   = 8'(h);
    padding_mode = 2'(mode);
    valid_in     = vld;
    data_in      = DATA_W'(dat);
    @(posedge clk);
    #1;
    start    = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic sendValue(input int dat);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, dat);
  endtask

  // Runs the replay with a repeating 4-cycle out_ready pattern until
  // frame_done, counting handshakes.
  task automatic drainFrame(input logic [3:0] pattern, input int n_expected, input string tag);
    int hs   = 0;
    int cyc  = 0;
    bit done = 1'b0;
    while (!done && cyc < 200) begin
      out_ready = pattern[2'(cyc % 4)];
      if (out_valid && out_ready) hs++;
      @(posedge clk);
      #1;
      if (frame_done) done = 1'b1;
      cyc++;
    end
    out_ready = 1'b1;
    checkOutput({tag, " drain finished"}, done, 1);
    checkOutput({tag, " handshakes"}, hs, n_expected);
    checkOutput({tag, " scoreboard empty"}, exp_q.size(), 0);
  endtask

  // Scoreboard: checks what the DUT shows now, then advances the model with
  // the inputs the coming rising edge will sample.
  always @(negedge clk) begin : scoreboard
    int   w, h, ow, oh, n;
    bit   bad;
    exp_t e;
    if (!rst_n) begin
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset err", err, 0);
      checkOutput("reset frame_done", frame_done, 0);
      exp_q.delete();
      recv_q.delete();
      m_phase = 0;
      m_err   = 1'b0;
      m_done  = 1'b0;
    end else begin
      checkOutput("busy", busy, (m_phase != 0) ? 1 : 0);
      checkOutput("err", err, m_err);
      checkOutput("frame_done", frame_done, m_done);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious out_valid", out_valid, 0);
        end else begin
          e = exp_q[0];
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_row", out_row, e.row);
          checkOutput("out_col", out_col, e.col);
          checkOutput("out_last", out_last, e.last);
          if (out_last) begin
            last_data = out_data;
            last_row  = out_row;
            last_col  = out_col;
          end
        end
      end

      m_done = 1'b0;
      case (m_phase)
        0: begin
          if (start) begin
            w = img_width;
            h = img_height;
            if (padding_mode == 2'b00) begin
              ow = w - 2;
              oh = h - 2;
            end else begin
              ow = w;
              oh = h;
            end
            n   = ow * oh;
            bad = ((padding_mode == 2'b00) && (w < 3 || h < 3)) || (n <= 0) || (n > MAX_SIZE);
            m_err = bad || valid_in;
            if (!bad) begin
              m_phase    = 1;
              m_expected = n;
              m_out_w    = ow;
              recv_q.delete();
            end
          end else if (valid_in) begin
            m_err = 1'b1;
          end
        end
        1: begin
          if (valid_in) begin
            recv_q.push_back(data_in);
            if (recv_q.size() == m_expected) begin
              for (int i = 0; i < m_expected; i++) begin
                e.data = recv_q[i];
                e.row  = i / m_out_w;
                e.col  = i % m_out_w;
                e.last = (i == m_expected - 1);
                exp_q.push_back(e);
              end
              recv_q.delete();
              m_phase = 2;
            end
          end
        end
        default: begin
          if (valid_in) m_err = 1'b1;
          if (out_valid && out_ready && exp_q.size() > 0) begin
            exp_q.delete(0);
            if (exp_q.size() == 0) begin
              m_phase = 0;
              m_done  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycle();

    $display("[TB] Scenario 1: zero padding, full-rate stream");
    out_ready = 1'b1;
    applyStimulus(1'b1, 4, 4, 1, 1'b0, 0);
    checkOutput("s1 busy after start", busy, 1);
    for (int i = 0; i < 16; i++) sendValue(i);
    drainFrame(4'b1111, 16, "s1");
    checkOutput("s1 last data", last_data, 15);
    checkOutput("s1 last row", last_row, 3);
    checkOutput("s1 last col", last_col, 3);
    checkOutput("s1 busy after last", busy, 0);
    idleCycle();
    checkOutput("s1 frame_done clears", frame_done, 0);

    $display("[TB] Scenario 2: no padding, gapped input");
    out_ready = 1'b0;
    applyStimulus(1'b1, 5, 4, 0, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      sendValue(vals2[i]);
      if (i < 5) idleCycle();
    end
    checkOutput("s2 out_valid after last edge", out_valid, 0);
    idleCycle();
    checkOutput("s2 out_valid one edge later", out_valid, 1);
    checkOutput("s2 first data", out_data, 10);
    checkOutput("s2 first row", out_row, 0);
    checkOutput("s2 first col", out_col, 0);
    drainFrame(4'b1111, 6, "s2");
    checkOutput("s2 last data", last_data, -60);
    checkOutput("s2 last row", last_row, 1);
    checkOutput("s2 last col", last_col, 2);
    idleCycle();

    $display("[TB] Scenario 3: backpressure");
    applyStimulus(1'b1, 4, 4, 1, 1'b0, 0);
    for (int i = 0; i < 16; i++) sendValue(i);
    drainFrame(4'b1001, 16, "s3");
    checkOutput("s3 last data", last_data, 15);
    idleCycle();

    $display("[TB] Scenario 4: configuration rejects");
    applyStimulus(1'b1, 2, 5, 0, 1'b0, 0);
    checkOutput("s4 narrow err", err, 1);
    checkOutput("s4 narrow busy", busy, 0);
    applyStimulus(1'b1, 17, 17, 1, 1'b0, 0);
    checkOutput("s4 oversize err", err, 1);
    checkOutput("s4 oversize busy", busy, 0);
    applyStimulus(1'b1, 3, 3, 1, 1'b0, 0);
    checkOutput("s4 accept err", err, 0);
    checkOutput("s4 accept busy", busy, 1);
    for (int i = 0; i < 9; i++) sendValue(i * 11 - 40);
    drainFrame(4'b1111, 9, "s4");
    checkOutput("s4 last data", last_data, 48);
    checkOutput("s4 last row", last_row, 2);
    checkOutput("s4 last col", last_col, 2);
    idleCycle();

    $display("[TB] Scenario 5: protocol violations");
    sendValue(77);
    checkOutput("s5 valid in idle err", err, 1);
    out_ready = 1'b0;
    applyStimulus(1'b1, 4, 4, 0, 1'b0, 0);
    checkOutput("s5 start clears err", err, 0);
    sendValue(5);
    sendValue(6);
    applyStimulus(1'b1, 8, 8, 1, 1'b1, 7);
    checkOutput("s5 start in collect err", err, 0);
    checkOutput("s5 start in collect busy", busy, 1);
    sendValue(8);
    sendValue(99);
    checkOutput("s5 valid in drain err", err, 1);
    checkOutput("s5 first data kept", out_data, 5);
    drainFrame(4'b1111, 4, "s5");
    checkOutput("s5 last data", last_data, 8);
    checkOutput("s5 last row", last_row, 1);
    checkOutput("s5 last col", last_col, 1);
    idleCycle();

    $display("[TB] Scenario 6: mid-frame reset and recovery");
    out_ready = 1'b1;
    applyStimulus(1'b1, 4, 4, 1, 1'b0, 0);
    for (int i = 0; i < 7; i++) sendValue(i + 20);
    rst_n = 1'b0;
    #1;
    checkOutput("s6 reset out_valid", out_valid, 0);
    checkOutput("s6 reset out_data", out_data, 0);
    checkOutput("s6 reset out_row", out_row, 0);
    checkOutput("s6 reset out_col", out_col, 0);
    checkOutput("s6 reset out_last", out_last, 0);
    checkOutput("s6 reset frame_done", frame_done, 0);
    checkOutput("s6 reset busy", busy, 0);
    checkOutput("s6 reset err", err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) idleCycle();
    checkOutput("s6 nothing replayed", out_valid, 0);
    applyStimulus(1'b1, 4, 4, 1, 1'b0, 0);
    for (int i = 0; i < 16; i++) sendValue(i * 7 - 50);
    drainFrame(4'b1111, 16, "s6");
    checkOutput("s6 last data", last_data, 55);
    checkOutput("s6 last row", last_row, 3);
    checkOutput("s6 last col", last_col, 3);
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/conv_output_frame_collector.md
# conv_output_frame_collector

Collects the raster-ordered stream of per-window results produced downstream of the 3x3 windowing stage, one result per window. Reassembles them into an output feature map in on-chip memory. Once the frame is complete, it replays the map to the next layer over a valid/ready handshake. The output frame size follows the same padding rule as the windowing stage: (H-2)x(W-2) for no padding, HxW for zero or edge padding.

## Interface
- `DATA_W`, default 8: signed result width.
- `MAX_SIZE`, default 256: memory depth in results; a frame larger than this is rejected.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle frame start; sampled only in IDLE.
- `img_width` input 8: input image width W, sampled with `start`.
- `img_height` input 8: input image height H, sampled with `start`.
- `padding_mode` input 2: 00 none, 01 zero, 10 edge, 11 treated as 01; sampled with `start`.
- `valid_in` input 1: result strobe from the compute stage; no backpressure.
- `data_in` input `DATA_W`, signed: result value.
- `out_valid` output 1: `out_data` holds a valid result.
- `out_ready` input 1: consumer accepts a result.
- `out_data` output `DATA_W`, signed: replayed result.
- `out_row` output 8: output-map row of `out_data`.
- `out_col` output 8: output-map column of `out_data`.
- `out_last` output 1: high with the final result of the frame.
- `frame_done` output 1: one-cycle pulse after the last handshake.
- `busy` output 1: high whenever the state is not IDLE.
- `err` output 1: sticky error flag; cleared only by `rst_n` or by an accepted `start`.

## Operation
- The state machine has three states: IDLE, COLLECT, DRAIN.
- **IDLE, on `start`:**
  - Latch the three configuration inputs.
  - Compute `out_w` and `out_h`: W-2 and H-2 for mode 00, otherwise W and H.
  - Compute `expected = out_w*out_h` as 16-bit unsigned.
  - If mode 00 and (W<3 or H<3), or `expected`==0, or `expected`>`MAX_SIZE`: set `err` and stay in IDLE.
  - Otherwise clear `err`, clear `wr_cnt`, and go to COLLECT.
- **COLLECT:**
  - Each `valid_in` writes `mem[wr_cnt]` and increments `wr_cnt`.
  - When `valid_in` arrives with `wr_cnt==expected-1`, go to DRAIN with `rd_cnt=0`, `row=0`, `col=0`.
- **DRAIN:**
  - Present `mem[rd_cnt]` together with `row`, `col`, and `out_last=(rd_cnt==expected-1)`.
  - On `out_valid && out_ready`: increment `rd_cnt`; `col` wraps at `out_w-1` to 0, and `row` then increments.
  - On the handshake of the last result: go to IDLE and pulse `frame_done`.
- **Event rules:**
  - `valid_in` in IDLE or DRAIN is dropped and sets `err`.
  - `start` outside IDLE is ignored and has no effect on `err`.
  - `start` and `valid_in` in the same IDLE cycle: `start` is processed and `valid_in` is dropped, setting `err`.
- **Output stability:** while `out_valid && !out_ready`, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
- **Reset values:** `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0, `frame_done`=0, `busy`=0, `err`=0, state=IDLE, all counters 0. Memory contents are not reset.
- **Reset mid-frame:** abandons the frame immediately; nothing partial is replayed afterwards.

## Timing
- `start` sampled at edge S: `busy` is high after S on accept, or `err` is high after S on reject.
- Each `valid_in` is written at its sampling edge, at full rate of one per cycle.
- Last `valid_in` sampled at edge E: `out_valid` is high after edge E+1 with result 0. This is one cycle of read prefetch.
- Throughput in DRAIN is one result per cycle while `out_ready` stays high, with no bubbles.
- Last handshake at edge L:
  - After L: `out_valid`=0, `out_last`=0, `frame_done`=1, `busy`=0.
  - After L+1: `frame_done`=0.
- A new `start` is accepted at edge L+1 at the earliest.

## Test plan
1. **Mode 01, full-rate stream.** W=H=4; send 16 results with values 0..15 back-to-back; `out_ready`=1.
   - Expect 16 outputs 0..15 in order, with `out_row`/`out_col` running (0,0)…(3,3).
   - Expect `out_last` only on value 15, and `frame_done` one cycle after it.
2. **Mode 00, gapped input.** W=5, H=4, so `expected`=6; send 6 results with a 1-cycle gap after each.
   - Expect rows/cols (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
   - Expect `out_valid` to rise exactly 2 edges after the last `valid_in`.
3. **Backpressure.** Same setup as scenario 1; toggle `out_ready` 1,0,0,1,…
   - Expect outputs held stable during stalls, no result lost or duplicated, and exactly 16 handshakes.
4. **Configuration rejects.**
   - W=2, H=5, mode 00: expect `err`=1 and `busy`=0.
   - Then W=H=17, mode 01 (289>256): expect `err` to stay 1.
   - Then W=H=3, mode 01: expect `err`=0 and `busy`=1.
5. **Protocol violations.**
   - `valid_in` in IDLE: expect `err`=1.
   - `start` during COLLECT: expect it ignored and the frame to complete normally.
   - `valid_in` during DRAIN: expect it dropped, `err`=1, and the replayed data unchanged.
6. **Mid-frame reset and recovery.** Assert `rst_n`=0 after 7 of 16 results.
   - Expect all outputs at reset values.
   - Then run a fresh W=H=4 frame: expect correct 16-result output.
